// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment frame capture block: active-low digit
// patterns, the blank pattern, the capture FSM state type and the default frame size.
package seg7_pkg;

  localparam int NDIGITS_DEF = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Element i holds the pattern for digit i.
  localparam logic [9:0][6:0] SEG_TABLE = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                           SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low seven-segment to BCD decoder; the blank pattern reads
// as 0 with blank set, anything unrecognised reads as 4'hF with invalid set.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       blank_o,
  output logic       invalid_o
);

  always_comb begin
    bcd_o     = 4'hF;
    blank_o   = 1'b0;
    invalid_o = 1'b1;
    if (seg_i == SEG_BLANK) begin
      bcd_o     = 4'h0;
      blank_o   = 1'b1;
      invalid_o = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (seg_i == SEG_TABLE[i]) begin
        bcd_o     = 4'(i);
        invalid_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Shifts NDIGITS decoded digits into a frame and holds it until the consumer takes it;
// out_valid rises on the edge accepting the last digit, and seg_ready is low while holding.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NDIGITS = NDIGITS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             seg,
  input  logic                   seg_valid,
  output logic                   seg_ready,
  input  logic                   abort,
  output logic [4*NDIGITS-1:0]   frame,
  output logic [NDIGITS-1:0]     blank_mask,
  output logic                   frame_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             err_count
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [4*NDIGITS-1:0]   frame_q, frame_d;
  logic [NDIGITS-1:0]     blank_q, blank_d;
  logic                   ferr_q;
  logic                   ovld_q;
  logic [7:0]             errc_q, errc_d;

  logic [3:0]             dec_bcd;
  logic                   dec_blank;
  logic                   dec_invalid;

  seg7_decode u_decode (
    .seg_i     (seg),
    .bcd_o     (dec_bcd),
    .blank_o   (dec_blank),
    .invalid_o (dec_invalid)
  );

  assign seg_ready = (state_q == COLLECT) && !abort;

  // Earlier digits migrate toward the MS nibble as new ones enter at the bottom.
  always_comb begin
    frame_d      = frame_q << 4;
    frame_d[3:0] = dec_bcd;
    blank_d      = blank_q << 1;
    blank_d[0]   = dec_blank;
    errc_d       = (dec_invalid && (errc_q != 8'hFF)) ? errc_q + 8'd1 : errc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      frame_q <= '0;
      blank_q <= '0;
      ferr_q  <= 1'b0;
      ovld_q  <= 1'b0;
      errc_q  <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (abort) begin
            idx_q   <= '0;
            frame_q <= '0;
            blank_q <= '0;
            ferr_q  <= 1'b0;
          end else if (seg_valid) begin
            frame_q <= frame_d;
            blank_q <= blank_d;
            ferr_q  <= ferr_q | dec_invalid;
            errc_q  <= errc_d;
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              state_q <= HOLD;
              ovld_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          // Clearing here gives the next frame a fresh blank/error history.
          if (out_ready) begin
            state_q <= COLLECT;
            ovld_q  <= 1'b0;
            frame_q <= '0;
            blank_q <= '0;
            ferr_q  <= 1'b0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign frame      = frame_q;
  assign blank_mask = blank_q;
  assign frame_err  = ferr_q;
  assign out_valid  = ovld_q;
  assign err_count  = errc_q;

endmodule
